// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Opcodes shared by the ALU control decoder and the iterative execution unit.
// The execution FSM state type is also kept here so that the interface can
// carry it as a debug field.
// Contents:
//   ALU_* : 4-bit operation codes
//   state_e : IDLE / BUSY / DONE
//   is_shift_op / is_mul_op : opcode class helpers
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_MUL = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == ALU_MUL);
    endfunction

endpackage

// File: rtl/iter_alu_exec_if.sv
// ---------------------------------------------------------------------------
// iter_alu_exec_if
// Request/response bundle for the iterative ALU execution unit.
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. A valid
// is never withdrawn by the unit before its transfer (except by flush or
// reset), and in_ready is low whenever a request would not be taken.
// Signals:
//   in_valid/in_ready, aluoperation, a, b : request side
//   flush                                 : synchronous abort
//   out_valid/out_ready, result, zero     : response side
//   dbg_state                             : current FSM state (observation)
// Modports: master = requester/consumer, slave = execution unit.
// ---------------------------------------------------------------------------
interface iter_alu_exec_if #(
    parameter int WIDTH = 32
);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       aluoperation;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    state_e           dbg_state;

    modport master (
        output in_valid, aluoperation, a, b, flush, out_ready,
        input  in_ready, out_valid, result, zero, dbg_state
    );

    modport slave (
        input  in_valid, aluoperation, a, b, flush, out_ready,
        output in_ready, out_valid, result, zero, dbg_state
    );

endinterface

// File: rtl/alu_simple_comb.sv
// ---------------------------------------------------------------------------
// alu_simple_comb
// Purely combinational evaluation of the single-cycle operations:
// AND, OR, XOR, ADD, SUB (modulo 2^WIDTH) and signed SLT. Any other opcode,
// including the iterative ones, yields 0.
// Ports:
//   i_op     : 4-bit operation code
//   i_a, i_b : operands
//   o_result : operation result
// ---------------------------------------------------------------------------
module alu_simple_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result
);

    logic w_lt;

    assign w_lt = ($signed(i_a) < $signed(i_b));

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, w_lt};
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/iter_alu_exec.sv
// ---------------------------------------------------------------------------
// iter_alu_exec
// Execution unit for the multi-cycle datapath. Simple ops finish in one
// cycle; shifts step one bit per cycle and MUL runs a shift-add loop over
// WIDTH cycles. Result and zero are registered and held until consumed.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : iter_alu_exec_if.slave (request, response, flush, debug state)
// ---------------------------------------------------------------------------
module iter_alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    iter_alu_exec_if.slave   bus
);

    localparam int SHW = $clog2(WIDTH);
    // One extra bit so the counter can hold WIDTH for the multiply loop.
    localparam int CW  = SHW + 1;

    state_e           r_state,  w_state_nxt;
    logic [WIDTH-1:0] r_acc,    w_acc_nxt;
    logic [WIDTH-1:0] r_mcand,  w_mcand_nxt;
    logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
    logic [CW-1:0]    r_cnt,    w_cnt_nxt;
    logic [3:0]       r_op,     w_op_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_zero,   w_zero_nxt;

    logic [WIDTH-1:0] w_simple;
    logic [WIDTH-1:0] w_step;
    logic [SHW-1:0]   w_shamt;

    alu_simple_comb #(.WIDTH(WIDTH)) u_simple (
        .i_op     (bus.aluoperation),
        .i_a      (bus.a),
        .i_b      (bus.b),
        .o_result (w_simple)
    );

    assign w_shamt = bus.b[SHW-1:0];

    // One iteration of the in-flight operation applied to the accumulator.
    always_comb begin
        w_step = r_acc;
        case (r_op)
            ALU_SLL: w_step = {r_acc[WIDTH-2:0], 1'b0};
            ALU_SRL: w_step = {1'b0, r_acc[WIDTH-1:1]};
            ALU_SRA: w_step = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
            ALU_MUL: w_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
            default: w_step = r_acc;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_cnt_nxt    = r_cnt;
        w_op_nxt     = r_op;
        w_result_nxt = r_result;
        w_zero_nxt   = r_zero;

        if (bus.flush) begin
            // Abort: drop whatever is in flight, keep the last result.
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        w_op_nxt = bus.aluoperation;
                        if (is_shift_op(bus.aluoperation)) begin
                            w_acc_nxt = bus.a;
                            w_cnt_nxt = {1'b0, w_shamt};
                            if (w_shamt == '0) begin
                                w_result_nxt = bus.a;
                                w_zero_nxt   = (bus.a == '0);
                                w_state_nxt  = DONE;
                            end else begin
                                w_state_nxt  = BUSY;
                            end
                        end else if (is_mul_op(bus.aluoperation)) begin
                            w_acc_nxt    = '0;
                            w_mcand_nxt  = bus.a;
                            w_mplier_nxt = bus.b;
                            w_cnt_nxt    = CW'(WIDTH);
                            w_state_nxt  = BUSY;
                        end else begin
                            w_result_nxt = w_simple;
                            w_zero_nxt   = (w_simple == '0);
                            w_state_nxt  = DONE;
                        end
                    end
                end
                BUSY: begin
                    w_acc_nxt = w_step;
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (is_mul_op(r_op)) begin
                        w_mcand_nxt  = {r_mcand[WIDTH-2:0], 1'b0};
                        w_mplier_nxt = {1'b0, r_mplier[WIDTH-1:1]};
                    end
                    // Last iteration: publish the post-step accumulator.
                    if (r_cnt == CW'(1)) begin
                        w_result_nxt = w_step;
                        w_zero_nxt   = (w_step == '0);
                        w_state_nxt  = DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_cnt    <= w_cnt_nxt;
            r_op     <= w_op_nxt;
            r_result <= w_result_nxt;
            r_zero   <= w_zero_nxt;
        end
    end

    // in_ready drops during flush so that a visible handshake always means
    // an accepted request.
    assign bus.in_ready  = (r_state == IDLE) && !bus.flush;
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.dbg_state = r_state;

endmodule
